// File: rtl/spi_tune_loader_if.sv
// SPI bus from the microcontroller into the tune loader.
// The master side drives all three wires. The loader only listens.
interface spi_tune_loader_if;
   logic sck;
   logic sdi;
   logic cs_n;

   modport master (output sck, output sdi, output cs_n);
   modport slave  (input  sck, input  sdi, input  cs_n);
endinterface

// File: rtl/spi_tune_loader.sv
// SPI slave that collects a note/tempo frame and commits it atomically to the tune block.
// Only a frame of exactly FRAME_BITS bits reaches the outputs. Any other length sets frame_err.
module spi_tune_loader #(
   parameter int NUM_NOTES   = 6,
   parameter int SPEED_BYTES = 5,
   parameter int FRAME_BITS  = (NUM_NOTES + SPEED_BYTES) * 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   spi_tune_loader_if.slave      bus,
   output logic [7:0]            sd0,
   output logic [7:0]            sd1,
   output logic [7:0]            sd2,
   output logic [7:0]            sd3,
   output logic [7:0]            sd4,
   output logic [7:0]            sd5,
   output logic [35:0]           clockSpeed,
   output logic                  start,
   output logic                  frame_err
);

   localparam logic [6:0] CNT_MAX   = 7'd127;
   localparam logic [6:0] FRAME_CNT = 7'(FRAME_BITS);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t                          state_q, state_d;
   logic [2:0]                      sck_sync_q, sck_sync_d;
   logic [2:0]                      cs_sync_q, cs_sync_d;
   logic [1:0]                      sdi_sync_q, sdi_sync_d;
   logic [6:0]                      bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0]           shadow_q, shadow_d;
   logic [NUM_NOTES-1:0][7:0]       notes_q, notes_d;
   logic [35:0]                     clock_speed_q, clock_speed_d;
   logic                            start_q, start_d;
   logic                            frame_err_q, frame_err_d;

   logic                            sck_rise;
   logic                            cs_fall;
   logic                            cs_rise;

   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];

   always_comb begin
      state_d       = state_q;
      sck_sync_d    = {sck_sync_q[1:0], bus.sck};
      cs_sync_d     = {cs_sync_q[1:0], bus.cs_n};
      sdi_sync_d    = {sdi_sync_q[0], bus.sdi};
      bit_cnt_d     = bit_cnt_q;
      shadow_d      = shadow_q;
      notes_d       = notes_q;
      clock_speed_d = clock_speed_q;
      start_d       = start_q;
      frame_err_d   = frame_err_q;

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               bit_cnt_d = 7'd0;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            // The end of the frame takes priority, so an sck edge in the same cycle is dropped.
            if (cs_rise) begin
               if (bit_cnt_q == FRAME_CNT) begin
                  start_d = 1'b0;
                  state_d = COMMIT;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end
            end else if (sck_rise) begin
               shadow_d = {shadow_q[FRAME_BITS-2:0], sdi_sync_q[1]};
               if (bit_cnt_q != CNT_MAX) begin
                  bit_cnt_d = bit_cnt_q + 7'd1;
               end
            end
         end

         COMMIT: begin
            for (int i = 0; i < NUM_NOTES; i++) begin
               notes_d[i] = shadow_q[FRAME_BITS-1-8*i -: 8];
            end
            clock_speed_d = shadow_q[35:0];
            frame_err_d   = 1'b0;
            start_d       = 1'b1;
            state_d       = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // cs_n synchronisers reset low. A frame that is still in progress when reset releases
   // therefore produces no falling edge, and its remaining bits are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         sck_sync_q    <= 3'b000;
         cs_sync_q     <= 3'b000;
         sdi_sync_q    <= 2'b00;
         bit_cnt_q     <= 7'd0;
         shadow_q      <= '0;
         notes_q       <= '0;
         clock_speed_q <= 36'd0;
         start_q       <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sck_sync_q    <= sck_sync_d;
         cs_sync_q     <= cs_sync_d;
         sdi_sync_q    <= sdi_sync_d;
         bit_cnt_q     <= bit_cnt_d;
         shadow_q      <= shadow_d;
         notes_q       <= notes_d;
         clock_speed_q <= clock_speed_d;
         start_q       <= start_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign sd0        = notes_q[0];
   assign sd1        = notes_q[1];
   assign sd2        = notes_q[2];
   assign sd3        = notes_q[3];
   assign sd4        = notes_q[4];
   assign sd5        = notes_q[5];
   assign clockSpeed = clock_speed_q;
   assign start      = start_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_tune_loader.sv
// Directed testbench for spi_tune_loader.
// Hand-computed frames are shifted in over a slow SPI link and the committed outputs are checked.
module tb_spi_tune_loader;

   localparam int HALF = 6;

   logic        clk;
   logic        reset_n;
   logic [7:0]  sd0, sd1, sd2, sd3, sd4, sd5;
   logic [35:0] clockSpeed;
   logic        start;
   logic        frame_err;

   int checksRun    = 0;
   int checksPassed = 0;

   localparam logic [87:0] FRAME_A  = 88'h05_0A_08_0F_05_05_00_00_00_00_14;
   localparam logic [87:0] FRAME_A2 = 88'h05_0A_08_0F_05_05_F1_00_00_00_14;
   localparam logic [87:0] FRAME_B  = 88'h01_02_03_04_05_06_00_00_00_00_28;

   spi_tune_loader_if bus ();

   spi_tune_loader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .sd0        (sd0),
      .sd1        (sd1),
      .sd2        (sd2),
      .sd3        (sd3),
      .sd4        (sd4),
      .sd5        (sd5),
      .clockSpeed (clockSpeed),
      .start      (start),
      .frame_err  (frame_err)
   );

   // 100 MHz system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
      checksRun++;
      assert (observed === expected) checksPassed++;
      else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   task automatic checkAll(input string tag, input logic [47:0] notes, input logic [35:0] speed,
                           input logic st, input logic err);
      checkOutput({tag, ".sd0"}, 36'(sd0), 36'(notes[47:40]));
      checkOutput({tag, ".sd1"}, 36'(sd1), 36'(notes[39:32]));
      checkOutput({tag, ".sd2"}, 36'(sd2), 36'(notes[31:24]));
      checkOutput({tag, ".sd3"}, 36'(sd3), 36'(notes[23:16]));
      checkOutput({tag, ".sd4"}, 36'(sd4), 36'(notes[15:8]));
      checkOutput({tag, ".sd5"}, 36'(sd5), 36'(notes[7:0]));
      checkOutput({tag, ".clockSpeed"}, clockSpeed, speed);
      checkOutput({tag, ".start"}, 36'(start), 36'(st));
      checkOutput({tag, ".frame_err"}, 36'(frame_err), 36'(err));
   endtask

   task automatic shiftBits(input logic [95:0] data, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.sdi = data[i];
         repeat (HALF) @(negedge clk);
         bus.sck = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.sck = 1'b0;
      end
      repeat (HALF) @(negedge clk);
   endtask

   // Drops cs_n and shifts the bits out MSB first. cs_n stays low afterwards.
   task automatic applyStimulus(input logic [95:0] data, input int nbits);
      @(negedge clk);
      bus.cs_n = 1'b0;
      repeat (8) @(negedge clk);
      shiftBits(data, nbits);
   endtask

   task automatic raiseCs();
      @(negedge clk);
      bus.cs_n = 1'b1;
   endtask

   task automatic settle();
      repeat (12) @(posedge clk);
      #1;
   endtask

   // Linear directed sequence covering reset, latency, malformed frames, idle sck noise and mid-frame reset.
   initial begin
      reset_n  = 1'b0;
      bus.sck  = 1'b0;
      bus.sdi  = 1'b0;
      bus.cs_n = 1'b1;
      repeat (4) @(negedge clk);
      checkAll("reset", 48'h0, 36'h0, 1'b0, 1'b0);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);

      applyStimulus({8'h00, FRAME_A}, 88);
      raiseCs();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("firstPre.sd0", 36'(sd0), 36'h0);
      checkOutput("firstPre.start", 36'(start), 36'h0);
      @(posedge clk);
      #1;
      checkAll("frameA", 48'h050A080F0505, 36'd20, 1'b1, 1'b0);
      settle();

      applyStimulus({8'h00, FRAME_A2}, 88);
      raiseCs();
      settle();
      checkAll("topNibble", 48'h050A080F0505, 36'h1_0000_0014, 1'b1, 1'b0);

      applyStimulus({16'h0000, FRAME_B[87:8]}, 80);
      raiseCs();
      settle();
      checkAll("short", 48'h050A080F0505, 36'h1_0000_0014, 1'b1, 1'b1);

      applyStimulus({FRAME_B, 8'hA5}, 96);
      raiseCs();
      settle();
      checkAll("long", 48'h050A080F0505, 36'h1_0000_0014, 1'b1, 1'b1);

      applyStimulus({8'h00, FRAME_B}, 88);
      raiseCs();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("pulseBefore.start", 36'(start), 36'h1);
      @(posedge clk);
      #1;
      checkOutput("pulseLow.start", 36'(start), 36'h0);
      checkOutput("pulseLow.sd0", 36'(sd0), 36'h5);
      @(posedge clk);
      #1;
      checkAll("frameB", 48'h010203040506, 36'd40, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("pulseAfter.start", 36'(start), 36'h1);
      settle();

      bus.sdi = 1'b1;
      for (int i = 0; i < 20; i++) begin
         repeat (HALF) @(negedge clk);
         bus.sck = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.sck = 1'b0;
      end
      settle();
      checkAll("idleSck", 48'h010203040506, 36'd40, 1'b1, 1'b0);
      applyStimulus({8'h00, FRAME_A}, 88);
      raiseCs();
      settle();
      checkAll("afterNoise", 48'h050A080F0505, 36'd20, 1'b1, 1'b0);

      applyStimulus({56'h0, FRAME_B[87:48]}, 40);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checkAll("midReset", 48'h0, 36'h0, 1'b0, 1'b0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      shiftBits({48'h0, FRAME_B[47:0]}, 48);
      raiseCs();
      settle();
      checkAll("noCommit", 48'h0, 36'h0, 1'b0, 1'b0);

      applyStimulus({8'h00, FRAME_A}, 88);
      raiseCs();
      settle();
      checkAll("recover", 48'h050A080F0505, 36'd20, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", checksPassed, checksRun);
      $finish;
   end

endmodule
